// File: rtl/cmd_link_pkg.sv
// Shared definitions for the 4-bit trigger command link.
// Contents:
//   - command code constants (also used by the receive-side trigger FSM)
//   - cmd_is_legal : legal-code check
//   - even_parity  : even parity over one frame data byte
//   - tx_state_t   : transmitter state encoding
//   - CMD_W / FRAME_W : command and frame data widths
package cmd_link_pkg;

  localparam int CMD_W   = 4;
  localparam int FRAME_W = 8;

  localparam logic [CMD_W-1:0] CMD_STOP   = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_TRIG_A = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_TRIG_B = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_TRIG_C = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_CONT_A = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_CONT_B = 4'b1000;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] code);
    logic legal;
    case (code)
      CMD_STOP, CMD_TRIG_A, CMD_TRIG_B, CMD_TRIG_C, CMD_CONT_A, CMD_CONT_B: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic even_parity(input logic [FRAME_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/cmd_tx_fifo.sv
// Synchronous command queue for cmd_uart_tx.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (flushes the queue)
//   push, din     : write request and data; ignored while full
//   pop, dout     : read request and head-of-queue data; pop ignored while empty
//   full, empty   : status flags
//   count         : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_tx_fifo
  import cmd_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_uart_tx.sv
// Host-side UART transmitter for the 4-bit trigger command link.
// Legal command codes are queued and each one is sent as the byte
// {4'b0000, cmd}, 8N1, LSB first. Build macro CMD_UART_TX_PARITY_EN
// inserts an even-parity bit after the data bits (8E1); nothing else changes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (aborts any frame, tx high)
//   cmd_vld   : command offered this cycle
//   cmd_in    : 4-bit command code
//   cmd_rdy   : queue can accept a command
//   cmd_err   : one-cycle pulse the cycle after an illegal code is offered
//   tx        : serial line, idle high
//   busy      : frame in progress or commands waiting
//   fifo_cnt  : commands waiting, not counting the one being sent
module cmd_uart_tx
  import cmd_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_vld,
  input  logic [CMD_W-1:0]              cmd_in,
  output logic                          cmd_rdy,
  output logic                          cmd_err,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  tx_state_t          state;
  tx_state_t          next_state;
  logic [BW-1:0]      baud;
  logic [BW-1:0]      baud_next;
  logic [2:0]         bit_idx;
  logic [2:0]         idx_next;
  logic [FRAME_W-1:0] shift;
  logic [FRAME_W-1:0] shift_next;
  logic               parity_bit;
  logic               parity_next;
  logic               tx_next;
  logic               legal;
  logic               push;
  logic               pop;
  logic [CMD_W-1:0]   fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      cnt_after;

  assign legal = cmd_is_legal(cmd_in);
  assign push  = cmd_vld & cmd_rdy & ~fifo_full & legal;

  cmd_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Frame sequencing: next state, baud count, bit index, shift register, queue pop.
  always_comb begin
    next_state  = state;
    baud_next   = baud;
    idx_next    = bit_idx;
    shift_next  = shift;
    parity_next = parity_bit;
    pop         = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_next  = {{(FRAME_W-CMD_W){1'b0}}, fifo_head};
          parity_next = even_parity({{(FRAME_W-CMD_W){1'b0}}, fifo_head});
          baud_next   = BAUD_LOAD;
          next_state  = TX_START;
        end else begin
          next_state  = TX_IDLE;
        end
      end
      TX_START: begin
        if (baud == BAUD_ZERO) begin
          baud_next  = BAUD_LOAD;
          idx_next   = 3'd0;
          next_state = TX_DATA;
        end else begin
          baud_next  = baud - BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (baud == BAUD_ZERO) begin
          baud_next = BAUD_LOAD;
          idx_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef CMD_UART_TX_PARITY_EN
            next_state = TX_PARITY;
`else
            next_state = TX_STOP;
`endif
          end else begin
            shift_next = {1'b0, shift[FRAME_W-1:1]};
          end
        end else begin
          baud_next = baud - BAUD_ONE;
        end
      end
      TX_PARITY: begin
        if (baud == BAUD_ZERO) begin
          baud_next  = BAUD_LOAD;
          next_state = TX_STOP;
        end else begin
          baud_next  = baud - BAUD_ONE;
        end
      end
      TX_STOP: begin
        if (baud == BAUD_ZERO) begin
          // Back-to-back frames: pop straight into START without an idle bit.
          if (!fifo_empty) begin
            pop         = 1'b1;
            shift_next  = {{(FRAME_W-CMD_W){1'b0}}, fifo_head};
            parity_next = even_parity({{(FRAME_W-CMD_W){1'b0}}, fifo_head});
            baud_next   = BAUD_LOAD;
            next_state  = TX_START;
          end else begin
            next_state  = TX_IDLE;
          end
        end else begin
          baud_next = baud - BAUD_ONE;
        end
      end
      default: begin
        next_state = TX_IDLE;
      end
    endcase
  end

  // Line level for the state being entered, so tx is a clean register output.
  always_comb begin
    tx_next = 1'b1;
    case (next_state)
      TX_IDLE:   tx_next = 1'b1;
      TX_START:  tx_next = 1'b0;
      TX_DATA:   tx_next = shift_next[0];
      TX_PARITY: tx_next = parity_next;
      TX_STOP:   tx_next = 1'b1;
      default:   tx_next = 1'b1;
    endcase
  end

  // Queue occupancy after this edge, used to register busy and cmd_rdy.
  always_comb begin
    cnt_after = fifo_cnt + CW'(push) - CW'(pop);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      baud       <= BAUD_ZERO;
      bit_idx    <= 3'd0;
      shift      <= {FRAME_W{1'b0}};
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      cmd_rdy    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= next_state;
      baud       <= baud_next;
      bit_idx    <= idx_next;
      shift      <= shift_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      busy       <= ~((next_state == TX_IDLE) && (cnt_after == {CW{1'b0}}));
      cmd_rdy    <= (cnt_after != CNT_FULL);
      // Illegal codes are flagged even when the queue is full.
      cmd_err    <= cmd_vld & ~legal;
    end
  end

endmodule

// File: tb/tb_cmd_uart_tx.sv
// Self-checking bench for cmd_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A behavioural model turns a list of offered commands into the expected
// per-cycle tx, busy, cmd_rdy, cmd_err and fifo_cnt sequences.
module tb_cmd_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CMD_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FC = FRAME_BITS * CPB;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       cmd_vld = 1'b0;
  logic [3:0] cmd_in  = 4'h0;
  logic       cmd_rdy;
  logic       cmd_err;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_cnt;

  int checks = 0;
  int errors = 0;

  logic obs_tx[$];
  logic obs_busy[$];
  logic obs_rdy[$];
  logic obs_err[$];
  int   obs_cnt[$];

  logic exp_tx[$];
  logic exp_busy[$];
  logic exp_rdy[$];
  logic exp_err[$];
  int   exp_cnt[$];
  int   n_cyc;

  cmd_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_vld  (cmd_vld),
    .cmd_in   (cmd_in),
    .cmd_rdy  (cmd_rdy),
    .cmd_err  (cmd_err),
    .tx       (tx),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] legal_code(input int k);
    logic [3:0] tbl [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0111, 4'b0100, 4'b1000};
    return tbl[k];
  endfunction

  function automatic logic is_legal(input logic [3:0] code);
    for (int k = 0; k < 6; k++) begin
      if (legal_code(k) == code) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] rand_illegal();
    logic [3:0] c;
    c = 4'(($urandom_range(0, 15)));
    while (is_legal(c)) c = 4'(($urandom_range(0, 15)));
    return c;
  endfunction

  // Serial level of bit position b (0 = start) of the frame carrying code.
  function automatic logic frame_bit(input logic [3:0] code, input int b);
    logic [7:0] data;
    data = {4'b0000, code};
    if (b == 0) return 1'b0;
    else if (b <= 8) return data[b-1];
`ifdef CMD_UART_TX_PARITY_EN
    else if (b == 9) return (($countones(data) % 2) == 1);
`endif
    else return 1'b1;
  endfunction

  // Items are {vld, code}; element i is offered before clock edge i and
  // expectation i is what the outputs show after edge i. All pushes are
  // assumed to happen within the first frame, so capacity is queue + 1.
  task automatic build_model(input logic [4:0] items[$]);
    logic [3:0] acc_codes[$];
    int         acc_at[$];
    int         s0, acc, started, cnt;
    logic       line;
    exp_tx.delete(); exp_busy.delete(); exp_rdy.delete(); exp_err.delete(); exp_cnt.delete();
    for (int i = 0; i < items.size(); i++) begin
      if (items[i][4] && is_legal(items[i][3:0]) && acc_codes.size() < DEPTH + 1) begin
        acc_codes.push_back(items[i][3:0]);
        acc_at.push_back(i);
      end
    end
    s0    = (acc_codes.size() > 0) ? acc_at[0] + 1 : 0;
    n_cyc = (acc_codes.size() > 0) ? s0 + acc_codes.size() * FC + 2 : items.size() + 2;
    for (int i = 0; i < n_cyc; i++) begin
      acc = 0; started = 0; line = 1'b1;
      for (int k = 0; k < acc_at.size(); k++) if (acc_at[k] <= i) acc++;
      for (int j = 0; j < acc_codes.size(); j++) begin
        if (s0 + j * FC <= i) started++;
        if (i >= s0 + j * FC && i < s0 + (j + 1) * FC)
          line = frame_bit(acc_codes[j], (i - s0 - j * FC) / CPB);
      end
      cnt = acc - started;
      exp_tx.push_back(line);
      exp_cnt.push_back(cnt);
      exp_rdy.push_back(cnt < DEPTH);
      exp_busy.push_back(acc > 0 && i < s0 + acc_codes.size() * FC);
      exp_err.push_back(i < items.size() && items[i][4] && !is_legal(items[i][3:0]));
    end
  endtask

  // Drive items one per cycle (starting at a negedge) and record outputs at each negedge.
  task automatic drive_and_capture(input logic [4:0] items[$], input int ncyc);
    obs_tx.delete(); obs_busy.delete(); obs_rdy.delete(); obs_err.delete(); obs_cnt.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (i < items.size()) begin
        cmd_vld = items[i][4];
        cmd_in  = items[i][3:0];
      end else begin
        cmd_vld = 1'b0;
        cmd_in  = 4'h0;
      end
      @(posedge clk);
      @(negedge clk);
      obs_tx.push_back(tx);
      obs_busy.push_back(busy);
      obs_rdy.push_back(cmd_rdy);
      obs_err.push_back(cmd_err);
      obs_cnt.push_back(int'(fifo_cnt));
    end
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fifo_cnt); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cmd_err); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task automatic test_single();
    logic [4:0] items[$];
    logic [8:0] head_bits;
    items.push_back(5'h11);
    build_model(items);
    drive_and_capture(items, n_cyc);
    head_bits = 9'b000000010;
    checks++; if (obs_tx[0] !== 1'b1) begin errors++; $display("FAIL single_latency_edge1: got %b expected 1", obs_tx[0]); end
    checks++; if (obs_tx[1] !== 1'b0) begin errors++; $display("FAIL single_latency_edge2: got %b expected 0", obs_tx[1]); end
    for (int b = 0; b < 9; b++) begin
      checks++;
      if (obs_tx[1 + b * CPB + CPB / 2] !== head_bits[b]) begin
        errors++; $display("FAIL single_bit%0d: got %b expected %b", b, obs_tx[1 + b * CPB + CPB / 2], head_bits[b]);
      end
    end
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL single_tx[%0d]: got %b expected %b", i, obs_tx[i], exp_tx[i]); end
      checks++;
      if (obs_busy[i] !== exp_busy[i]) begin errors++; $display("FAIL single_busy[%0d]: got %b expected %b", i, obs_busy[i], exp_busy[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] items[$];
    items.push_back(5'h14);
    items.push_back(5'h18);
    items.push_back(5'h10);
    build_model(items);
    drive_and_capture(items, n_cyc);
    checks++; if (obs_cnt[2] !== 2) begin errors++; $display("FAIL b2b_cnt_peak: got %0d expected 2", obs_cnt[2]); end
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL b2b_tx[%0d]: got %b expected %b", i, obs_tx[i], exp_tx[i]); end
      checks++;
      if (obs_cnt[i] !== exp_cnt[i]) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, obs_cnt[i], exp_cnt[i]); end
    end
  endtask

  task automatic test_full();
    logic [4:0] items[$];
    for (int k = 0; k < 6; k++) items.push_back({1'b1, legal_code($urandom_range(0, 5))});
    items.push_back({1'b1, rand_illegal()});
    build_model(items);
    drive_and_capture(items, n_cyc);
    checks++; if (obs_rdy[4] !== 1'b0) begin errors++; $display("FAIL full_rdy_after_5th: got %b expected 0", obs_rdy[4]); end
    checks++; if (obs_err[5] !== 1'b0) begin errors++; $display("FAIL full_6th_no_err: got %b expected 0", obs_err[5]); end
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL full_tx[%0d]: got %b expected %b", i, obs_tx[i], exp_tx[i]); end
      checks++;
      if (obs_cnt[i] !== exp_cnt[i]) begin errors++; $display("FAIL full_cnt[%0d]: got %0d expected %0d", i, obs_cnt[i], exp_cnt[i]); end
      checks++;
      if (obs_rdy[i] !== exp_rdy[i]) begin errors++; $display("FAIL full_rdy[%0d]: got %b expected %b", i, obs_rdy[i], exp_rdy[i]); end
      checks++;
      if (obs_err[i] !== exp_err[i]) begin errors++; $display("FAIL full_err[%0d]: got %b expected %b", i, obs_err[i], exp_err[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] items[$];
    items.push_back(5'h13);
    items.push_back(5'h00);
    items.push_back(5'h1F);
    items.push_back(5'h00);
    items.push_back({1'b1, rand_illegal()});
    items.push_back(5'h00);
    build_model(items);
    drive_and_capture(items, n_cyc);
    checks++; if (obs_err[0] !== 1'b1) begin errors++; $display("FAIL illegal_0011_err: got %b expected 1", obs_err[0]); end
    checks++; if (obs_err[2] !== 1'b1) begin errors++; $display("FAIL illegal_1111_err: got %b expected 1", obs_err[2]); end
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if (obs_err[i] !== exp_err[i]) begin errors++; $display("FAIL illegal_err[%0d]: got %b expected %b", i, obs_err[i], exp_err[i]); end
      checks++;
      if (obs_cnt[i] !== exp_cnt[i]) begin errors++; $display("FAIL illegal_cnt[%0d]: got %0d expected %0d", i, obs_cnt[i], exp_cnt[i]); end
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL illegal_tx[%0d]: got %b expected %b", i, obs_tx[i], exp_tx[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] items[$];
    items.push_back(5'h17);
    items.push_back(5'h11);
    build_model(items);
    // Frame starts at sample 1; sample 18 is frame cycle 17, inside data bit 3.
    drive_and_capture(items, 19);
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL midrst_pre_tx[%0d]: got %b expected %b", i, obs_tx[i], exp_tx[i]); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", fifo_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b expected 1", cmd_rdy); end
    items.delete();
    items.push_back({1'b1, legal_code($urandom_range(0, 5))});
    build_model(items);
    drive_and_capture(items, n_cyc);
    for (int i = 0; i < n_cyc; i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL midrst_post_tx[%0d]: got %b expected %b", i, obs_tx[i], exp_tx[i]); end
      checks++;
      if (obs_busy[i] !== exp_busy[i]) begin errors++; $display("FAIL midrst_post_busy[%0d]: got %b expected %b", i, obs_busy[i], exp_busy[i]); end
    end
  endtask

  task automatic test_random();
    logic [4:0] items[$];
    int         len, r;
    for (int round = 0; round < 4; round++) begin
      items.delete();
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        if (r < 6) items.push_back({1'b1, legal_code($urandom_range(0, 5))});
        else if (r < 8) items.push_back({1'b1, rand_illegal()});
        else items.push_back({1'b0, 4'(($urandom_range(0, 15)))});
      end
      build_model(items);
      drive_and_capture(items, n_cyc);
      for (int i = 0; i < n_cyc; i++) begin
        checks++;
        if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL rand%0d_tx[%0d]: got %b expected %b", round, i, obs_tx[i], exp_tx[i]); end
        checks++;
        if (obs_cnt[i] !== exp_cnt[i]) begin errors++; $display("FAIL rand%0d_cnt[%0d]: got %0d expected %0d", round, i, obs_cnt[i], exp_cnt[i]); end
        checks++;
        if (obs_rdy[i] !== exp_rdy[i]) begin errors++; $display("FAIL rand%0d_rdy[%0d]: got %b expected %b", round, i, obs_rdy[i], exp_rdy[i]); end
        checks++;
        if (obs_err[i] !== exp_err[i]) begin errors++; $display("FAIL rand%0d_err[%0d]: got %b expected %b", round, i, obs_err[i], exp_err[i]); end
        checks++;
        if (obs_busy[i] !== exp_busy[i]) begin errors++; $display("FAIL rand%0d_busy[%0d]: got %b expected %b", round, i, obs_busy[i], exp_busy[i]); end
      end
    end
  endtask

`ifdef CMD_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [4:0] items[$];
    logic [3:0] codes [2] = '{4'b0111, 4'b0000};
    logic       pbits [2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      items.delete();
      items.push_back({1'b1, codes[t]});
      build_model(items);
      drive_and_capture(items, n_cyc);
      checks++;
      if (obs_tx[1 + 9 * CPB + 1] !== pbits[t]) begin
        errors++; $display("FAIL parity_bit_%0d: got %b expected %b", t, obs_tx[1 + 9 * CPB + 1], pbits[t]);
      end
      checks++; if (obs_busy[44] !== 1'b1) begin errors++; $display("FAIL parity_len_busy44_%0d: got %b expected 1", t, obs_busy[44]); end
      checks++; if (obs_busy[45] !== 1'b0) begin errors++; $display("FAIL parity_len_busy45_%0d: got %b expected 0", t, obs_busy[45]); end
      for (int i = 0; i < n_cyc; i++) begin
        checks++;
        if (obs_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL parity%0d_tx[%0d]: got %b expected %b", t, i, obs_tx[i], exp_tx[i]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_illegal();
    test_reset_mid_frame();
    test_random();
`ifdef CMD_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
